strand_select_stage: RTL
========================

# strand_select_stage

Per-strand issue scheduler between the instruction fetch stage and decode. Each cycle it picks at most one strand with a ready instruction at the head of its instruction FIFO and dequeues it. The instruction is registered toward decode. The block holds strands idle while a long-latency op drains, while a data-cache miss is outstanding, or while the strand is disabled.

## Interface
- STRANDS, default 4: strands per core (= `STRANDS_PER_CORE`).
- LL_STALL, default 3: cycles a strand is ineligible after issuing a long-latency instruction; range 1..15.
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- if_instruction_valid  in  STRANDS  FIFO head valid per strand.
- if_instruction  in  STRANDS*32  head instruction; strand i at [i*32+:32].
- if_pc  in  STRANDS*32  head PC+4 per strand.
- if_branch_predicted  in  STRANDS  head predicted-taken flag.
- if_long_latency  in  STRANDS  head long-latency flag.
- ss_instruction_req  out  STRANDS  one-hot dequeue; combinational, same cycle as grant.
- rb_rollback_strand  in  STRANDS  rollback per strand (fetch FIFO flushing this cycle).
- dc_suspend_strand  in  STRANDS  strand took a data-cache miss.
- dc_resume_strand  in  STRANDS  miss for strand completed.
- strand_enable  in  STRANDS  strand may issue.
- ss_instruction_valid  out  1  output register holds an issued instruction.
- ss_instruction  out  32  issued instruction.
- ss_pc  out  32  issued PC+4.
- ss_strand  out  clog2(STRANDS)  issued strand index.
- ss_branch_predicted  out  1  issued branch-predicted flag.
- ss_long_latency  out  1  issued long-latency flag.

## Operation
Each strand has a state machine: READY, LL_WAIT (with a 4-bit counter) and SUSPENDED.
- Eligible(i) requires all of:
  - state READY;
  - if_instruction_valid[i];
  - strand_enable[i];
  - not rb_rollback_strand[i];
  - not dc_suspend_strand[i].
- Round-robin arbitration:
  - Search starts at the strand after the last granted strand.
  - At most one grant per cycle.
  - The pointer advances only on a grant.
- A grant to strand i asserts ss_instruction_req[i]. The head fields of strand i load the output register at the next edge, and ss_instruction_valid is set.
- With no grant, ss_instruction_valid is 0 the next cycle and the data fields hold their previous values.
- Issue with if_long_latency=1: strand goes READY→LL_WAIT with count=LL_STALL. Each cycle the count decrements. When count reaches 1, the next state is READY.
- dc_suspend_strand[i]: any state → SUSPENDED.
- dc_resume_strand[i] in SUSPENDED → READY.
- Priority per strand, highest first:
  - suspend (rollback also asserted or not) → SUSPENDED;
  - resume → READY;
  - rollback → READY, counter cleared;
  - otherwise normal transition.
- Suspend and resume in the same cycle: SUSPENDED.
- Resume while not SUSPENDED: ignored.
- Disabled strands keep their state and counter, but never issue.

## Timing
- Reset values:
  - all strands READY, counters 0;
  - RR pointer = STRANDS-1, so strand 0 has first priority;
  - ss_instruction_req=0, ss_instruction_valid=0;
  - ss_instruction, ss_pc, ss_strand, ss_branch_predicted, ss_long_latency all 0.
- Latency: grant in cycle N → ss_* valid in cycle N+1. Throughput is 1 instruction/cycle across strands.
- A single strand without long-latency ops can issue every cycle.
- After a long-latency issue in cycle N, the strand's next issue is no earlier than cycle N+LL_STALL+1.
- Rollback in cycle N blocks strand i in N. The strand is eligible again in N+1, subject to FIFO refill.
- Reset asserted mid-operation clears everything immediately (async). The first grant is possible in the first cycle after deassertion.
- The RR pointer wraps from STRANDS-1 to 0.

## Structure
- Shared package `strand_select_pkg`:
  - typedef strand_state_t {READY, LL_WAIT, SUSPENDED};
  - counter width constant (4).
- Sub-module `strand_rr_arbiter`:
  - parameter NUM_ENTRIES;
  - inputs request, advance; output grant_oh;
  - internal last-grant pointer;
  - async reset.
- Per-strand FSM built in a generate loop. A one-hot-to-index conversion produces ss_strand.

## Test plan
- Reset, then all 4 strands valid and enabled → grants in order 0,1,2,3,0. ss_strand follows one cycle later; ss_instruction_req one-hot each cycle.
- Strand 1 alone issues a long-latency op in cycle 10 with LL_STALL=3 → ss_instruction_req[1] is 0 in cycles 11-13 and 1 in cycle 14.
- dc_suspend_strand[2] with dc_resume_strand[2] 20 cycles later, others idle → no grant to strand 2 during suspend; grant resumes the cycle after resume.
- Strand 0 in LL_WAIT, rb_rollback_strand[0] pulsed → no grant that cycle; strand 0 READY and granted in the next cycle when valid.
- Same-cycle dc_suspend_strand[3] and rb_rollback_strand[3] → strand 3 SUSPENDED; stays blocked until dc_resume_strand[3].
- strand_enable=4'b0100, all valid → only strand 2 issues, every cycle. Assert reset mid-run → ss_instruction_valid drops to 0 asynchronously.

Source files
------------

// File: rtl/strand_select_pkg.sv
// strand_select_pkg
//   Types and constants shared by the strand select stage and its arbiter.
//   - strand_state_t : per-strand scheduling state
//   - LL_CNT_W       : width of the long-latency drain counter
package strand_select_pkg;

  localparam int LL_CNT_W = 4;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    LL_WAIT   = 2'd1,
    SUSPENDED = 2'd2
  } strand_state_t;

endpackage

// File: rtl/strand_rr_arbiter.sv
// strand_rr_arbiter
//   Round-robin arbiter. The search starts at the entry after the last granted
//   one; the pointer moves only when a grant is taken (advance).
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     request_i    : per-entry request
//     advance_i    : commit the current grant to the pointer
//     grant_oh_o   : one-hot grant (combinational)
module strand_rr_arbiter #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ENTRIES-1:0] request_i,
  input  logic                   advance_i,
  output logic [NUM_ENTRIES-1:0] grant_oh_o
);

  localparam int PW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] idx;
  logic          found;

  // Walk offsets 1..N from the pointer so the last winner has lowest priority.
  always_comb begin
    grant_oh_o = '0;
    grant_idx  = ptr_q;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NUM_ENTRIES; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_ENTRIES);
      if (!found && request_i[idx]) begin
        grant_oh_o[idx] = 1'b1;
        grant_idx       = idx;
        found           = 1'b1;
      end
    end
  end

  // Reset to the last entry so entry 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PW'(NUM_ENTRIES - 1);
    end else if (advance_i && found) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/strand_select_stage.sv
// strand_select_stage
//   Picks at most one eligible strand per cycle, dequeues its fetch FIFO head
//   and registers the instruction toward decode.
//   Ports:
//     clk, reset             : clock, asynchronous active-high reset
//     if_*                   : per-strand FIFO head fields (32-bit lanes)
//     ss_instruction_req     : one-hot dequeue, same cycle as grant
//     rb_rollback_strand     : fetch FIFO flush per strand
//     dc_suspend/resume      : data-cache miss start / completion per strand
//     strand_enable          : strand may issue
//     ss_*                   : registered issued instruction, one cycle later
module strand_select_stage
  import strand_select_pkg::*;
#(
  parameter int STRANDS  = 4,
  parameter int LL_STALL = 3,
  localparam int SW      = (STRANDS > 1) ? $clog2(STRANDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [STRANDS-1:0]    if_instruction_valid,
  input  logic [STRANDS*32-1:0] if_instruction,
  input  logic [STRANDS*32-1:0] if_pc,
  input  logic [STRANDS-1:0]    if_branch_predicted,
  input  logic [STRANDS-1:0]    if_long_latency,
  output logic [STRANDS-1:0]    ss_instruction_req,
  input  logic [STRANDS-1:0]    rb_rollback_strand,
  input  logic [STRANDS-1:0]    dc_suspend_strand,
  input  logic [STRANDS-1:0]    dc_resume_strand,
  input  logic [STRANDS-1:0]    strand_enable,
  output logic                  ss_instruction_valid,
  output logic [31:0]           ss_instruction,
  output logic [31:0]           ss_pc,
  output logic [SW-1:0]         ss_strand,
  output logic                  ss_branch_predicted,
  output logic                  ss_long_latency
);

  logic [STRANDS-1:0] eligible;
  logic [STRANDS-1:0] grant_oh;
  logic               any_grant;

  strand_rr_arbiter #(.NUM_ENTRIES(STRANDS)) u_arb (
    .clk        (clk),
    .rst        (reset),
    .request_i  (eligible),
    .advance_i  (any_grant),
    .grant_oh_o (grant_oh)
  );

  assign any_grant          = |grant_oh;
  assign ss_instruction_req = grant_oh;

  genvar gi;
  generate
    for (gi = 0; gi < STRANDS; gi++) begin : g_strand
      strand_state_t       state_q, state_d;
      logic [LL_CNT_W-1:0] cnt_q, cnt_d;

      // Reset gates eligibility so no dequeue is requested while held in reset.
      assign eligible[gi] = ~reset && (state_q == READY) && if_instruction_valid[gi]
                            && strand_enable[gi] && ~rb_rollback_strand[gi]
                            && ~dc_suspend_strand[gi];

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (dc_suspend_strand[gi]) begin
          state_d = SUSPENDED;
        end else if (dc_resume_strand[gi] && state_q == SUSPENDED) begin
          state_d = READY;
        end else if (rb_rollback_strand[gi]) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          case (state_q)
            READY: begin
              if (grant_oh[gi] && if_long_latency[gi]) begin
                state_d = LL_WAIT;
                cnt_d   = LL_CNT_W'(LL_STALL);
              end
            end
            LL_WAIT: begin
              // A count of 1 is the final stall cycle.
              if (cnt_q <= LL_CNT_W'(1)) begin
                state_d = READY;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= READY;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end
    end
  endgenerate

  // One-hot grant to index, plus head-field mux of the winning strand.
  logic [SW-1:0] grant_idx;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic          head_bp;
  logic          head_ll;

  always_comb begin
    grant_idx  = '0;
    head_instr = '0;
    head_pc    = '0;
    head_bp    = 1'b0;
    head_ll    = 1'b0;
    for (int i = 0; i < STRANDS; i++) begin
      if (grant_oh[i]) begin
        grant_idx  = SW'(i);
        head_instr = if_instruction[i*32 +: 32];
        head_pc    = if_pc[i*32 +: 32];
        head_bp    = if_branch_predicted[i];
        head_ll    = if_long_latency[i];
      end
    end
  end

  logic          valid_q;
  logic [31:0]   instr_q;
  logic [31:0]   pc_q;
  logic [SW-1:0] strand_q;
  logic          bp_q;
  logic          ll_q;

  // Data fields hold their last value when nothing issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      strand_q <= '0;
      bp_q     <= 1'b0;
      ll_q     <= 1'b0;
    end else begin
      valid_q <= any_grant;
      if (any_grant) begin
        instr_q  <= head_instr;
        pc_q     <= head_pc;
        strand_q <= grant_idx;
        bp_q     <= head_bp;
        ll_q     <= head_ll;
      end
    end
  end

  assign ss_instruction_valid = valid_q;
  assign ss_instruction       = instr_q;
  assign ss_pc                = pc_q;
  assign ss_strand            = strand_q;
  assign ss_branch_predicted  = bp_q;
  assign ss_long_latency      = ll_q;

endmodule
